// File: rtl/vector_comb.sv
// vector_comb: per-bin vector comb, y[n] = x[n] - beta * x[n-L] with L = vector length.
// A circular delay RAM keeps the previous vector; samples move through a 3-stage pipeline:
// S0 (delay RAM read), S1 (beta multiply), S2 (subtract / round / saturate into output regs).
// Optional feature macro: VECTOR_COMB_GAIN_EN enables the SR_GAIN output left shift (0..15).
module vector_comb #(
    parameter logic [7:0] SR_VECTOR_LEN    = 8'd0,
    parameter logic [7:0] SR_BETA          = 8'd1,
    parameter logic [7:0] SR_GAIN          = 8'd2,
    parameter int         MAX_LOG2_OF_SIZE = 10,
    parameter int         IWIDTH           = 16,
    parameter int         OWIDTH           = 16,
    parameter int         BETAWIDTH        = 18
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  set_stb,
    input  logic [7:0]            set_addr,
    input  logic [31:0]           set_data,
    input  logic [2*IWIDTH-1:0]   i_tdata,
    input  logic                  i_tlast,
    input  logic                  i_tvalid,
    output logic                  i_tready,
    output logic [2*OWIDTH-1:0]   o_tdata,
    output logic                  o_tlast,
    output logic                  o_tvalid,
    input  logic                  o_tready
);

    localparam int AW    = MAX_LOG2_OF_SIZE;
    localparam int DEPTH = 1 << AW;
    localparam int PW    = IWIDTH + BETAWIDTH;      // product width
    localparam int DW    = PW + 1;                  // difference width, cannot overflow
    localparam int FRAC  = BETAWIDTH - 1;           // beta fractional bits
`ifdef VECTOR_COMB_GAIN_EN
    localparam int SW    = DW + 15;                 // room for the largest gain shift
`else
    localparam int SW    = DW;
`endif
    // Half an LSB of the output, added before the arithmetic right shift (round half up)
    localparam logic signed [SW-1:0] RND = {{(SW-BETAWIDTH+1){1'b0}}, 1'b1, {(BETAWIDTH-2){1'b0}}};

    // Handshake and control
    logic                        w_adv;
    logic                        w_accept;
    logic                        w_len_wr;
    logic [AW:0]                 w_new_len;
    logic [AW-1:0]               w_new_last;
    logic [AW-1:0]               w_last_eff;
    logic [AW-1:0]               w_idx_cur;
    logic                        w_primed_cur;
    logic                        w_wrap;

    // Settings and vector position
    logic [AW-1:0]               r_last_idx;
    logic signed [BETAWIDTH-1:0] r_beta;
    logic [AW-1:0]               r_idx;
    logic                        r_primed;

    // Delay RAM
    logic [2*IWIDTH-1:0]         r_mem [DEPTH];
    logic [2*IWIDTH-1:0]         r_ram_q;

    // Pipeline stages
    logic                        r_s0_valid;
    logic [2*IWIDTH-1:0]         r_s0_x;
    logic                        r_s0_last;
    logic                        r_s0_primed;
    logic signed [BETAWIDTH-1:0] r_s0_beta;
    logic                        r_s1_valid;
    logic [2*IWIDTH-1:0]         r_s1_x;
    logic [2*PW-1:0]             r_s1_p;
    logic                        r_s1_last;
    logic [2*PW-1:0]             w_p_all;
    logic [2*OWIDTH-1:0]         w_y_all;

`ifdef VECTOR_COMB_GAIN_EN
    logic [3:0]                  r_gain;
    logic [3:0]                  r_s0_gain;
    logic [3:0]                  r_s1_gain;
`endif

    logic                        w_unused;
`ifdef VECTOR_COMB_GAIN_EN
    assign w_unused = ^set_data;
`else
    assign w_unused = ^{set_data, (set_addr == SR_GAIN)};
`endif

    assign w_adv    = ~o_tvalid | o_tready;
    assign i_tready = w_adv & ~reset & ~clear;
    assign w_accept = i_tvalid & i_tready;
    assign w_len_wr = set_stb && (set_addr == SR_VECTOR_LEN);

    // A length write restarts the vector in the same cycle, so a coincident sample lands at bin 0
    assign w_new_len    = set_data[AW:0];
    assign w_last_eff   = w_len_wr ? w_new_last : r_last_idx;
    assign w_idx_cur    = w_len_wr ? '0 : r_idx;
    assign w_primed_cur = w_len_wr ? 1'b0 : r_primed;
    assign w_wrap       = (w_idx_cur == w_last_eff);

    // Map the written length to the last bin index: 0 behaves as 1, oversize clamps to the RAM depth
    always_comb begin
        w_new_last = '0;
        if (w_new_len == '0) begin
            w_new_last = '0;
        end else if (w_new_len[AW]) begin
            w_new_last = '1;
        end else begin
            w_new_last = w_new_len[AW-1:0] - AW'(1);
        end
    end

    // Settings registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last_idx <= '0;
            r_beta     <= '0;
`ifdef VECTOR_COMB_GAIN_EN
            r_gain     <= '0;
`endif
        end else if (set_stb) begin
            if (set_addr == SR_VECTOR_LEN) begin
                r_last_idx <= w_new_last;
            end
            if (set_addr == SR_BETA) begin
                r_beta <= set_data[31 -: BETAWIDTH];
            end
`ifdef VECTOR_COMB_GAIN_EN
            if (set_addr == SR_GAIN) begin
                r_gain <= set_data[3:0];
            end
`endif
        end
    end

    // Bin index and primed flag: primed once a full vector has been stored
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_idx    <= '0;
            r_primed <= 1'b0;
        end else if (w_accept) begin
            r_idx    <= w_wrap ? '0 : w_idx_cur + AW'(1);
            r_primed <= w_primed_cur | w_wrap;
        end else if (w_len_wr) begin
            r_idx    <= '0;
            r_primed <= 1'b0;
        end
    end

    // Delay RAM, read-first: the old bin value is read while the new sample overwrites it
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_ram_q          <= r_mem[w_idx_cur];
            r_mem[w_idx_cur] <= i_tdata;
        end
    end

    // Per-lane arithmetic; lane 1 is I (upper half), lane 0 is Q
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_lane
            logic signed [IWIDTH-1:0] w_xold;
            logic signed [PW-1:0]     w_p;
            logic signed [IWIDTH-1:0] w_x1;
            logic signed [PW-1:0]     w_p1;
            logic signed [DW-1:0]     w_d;
            logic signed [SW-1:0]     w_ds;
            logic signed [SW-1:0]     w_r;
            logic                     w_fits;

            // Until primed the delayed term is zero so stale RAM contents never reach the output
            assign w_xold = r_s0_primed ? r_ram_q[gi*IWIDTH +: IWIDTH] : '0;
            assign w_p    = PW'(r_s0_beta) * PW'(w_xold);
            assign w_p_all[gi*PW +: PW] = w_p;

            assign w_x1 = r_s1_x[gi*IWIDTH +: IWIDTH];
            assign w_p1 = r_s1_p[gi*PW +: PW];
            assign w_d  = (DW'(w_x1) <<< FRAC) - DW'(w_p1);
`ifdef VECTOR_COMB_GAIN_EN
            assign w_ds = SW'(w_d) <<< r_s1_gain;
`else
            assign w_ds = w_d;
`endif
            assign w_r    = (w_ds + RND) >>> FRAC;
            assign w_fits = (&w_r[SW-1:OWIDTH-1]) | ~(|w_r[SW-1:OWIDTH-1]);
            assign w_y_all[gi*OWIDTH +: OWIDTH] = w_fits ? w_r[OWIDTH-1:0]
                                                         : {w_r[SW-1], {(OWIDTH-1){~w_r[SW-1]}}};
        end
    endgenerate

    // Pipeline advance: every stage shifts together whenever the output can move
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s0_valid <= 1'b0;
            r_s1_valid <= 1'b0;
            o_tvalid   <= 1'b0;
            o_tdata    <= '0;
            o_tlast    <= 1'b0;
        end else if (clear) begin
            r_s0_valid <= 1'b0;
            r_s1_valid <= 1'b0;
            o_tvalid   <= 1'b0;
        end else if (w_adv) begin
            r_s0_valid <= w_accept;
            if (w_accept) begin
                r_s0_x      <= i_tdata;
                r_s0_last   <= i_tlast;
                r_s0_primed <= w_primed_cur;
                r_s0_beta   <= r_beta;
`ifdef VECTOR_COMB_GAIN_EN
                r_s0_gain   <= r_gain;
`endif
            end
            r_s1_valid <= r_s0_valid;
            if (r_s0_valid) begin
                r_s1_x    <= r_s0_x;
                r_s1_p    <= w_p_all;
                r_s1_last <= r_s0_last;
`ifdef VECTOR_COMB_GAIN_EN
                r_s1_gain <= r_s0_gain;
`endif
            end
            o_tvalid <= r_s1_valid;
            if (r_s1_valid) begin
                o_tdata <= w_y_all;
                o_tlast <= r_s1_last;
            end
        end
    end

endmodule
